// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, FSM states,
// error codes and instruction word field positions.
package seq_pkg;

  typedef enum logic [7:0] {
    OP_NOP   = 8'h00,
    OP_WRITE = 8'h01,
    OP_READ  = 8'h02,
    OP_JUMP  = 8'h03,
    OP_DELAY = 8'h04,
    OP_HALT  = 8'h0F
  } opcode_e;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_MEMWAIT, S_DECODE, S_ISSUE,
    S_WAITBUS, S_DELAY, S_HALTED, S_ERROR
  } state_e;

  // ERR_MEM stands for the whole range of nonzero codes passed through from memory.
  localparam logic [3:0] ERR_NONE   = 4'h0;
  localparam logic [3:0] ERR_MEM    = 4'h1;
  localparam logic [3:0] ERR_OPCODE = 4'h2;
  localparam logic [3:0] ERR_JUMP   = 4'h3;
  localparam logic [3:0] ERR_PC_OVF = 4'h4;

  // Instruction word layout: [31:24] opcode, [23:16] sensor reg, [15:0] operand.
  localparam int OPC_MSB   = 31;
  localparam int OPC_LSB   = 24;
  localparam int RADDR_MSB = 23;
  localparam int RADDR_LSB = 16;
  localparam int OPND_MSB  = 15;
  localparam int OPND_LSB  = 0;

endpackage

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches words from register memory, decodes them and
// drives sensor register transactions on the serial bus master handshake.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int MEMORY_SIZE = 255,
  parameter int DELAY_W     = 16,
  localparam int ADDR_W     = $clog2(MEMORY_SIZE + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic [ADDR_W-1:0] reg_addr,
  input  logic [31:0]       reg_data,
  input  logic [3:0]        mem_error,
  output logic              bus_req,
  input  logic              bus_ack,
  output logic              bus_rw,
  output logic [7:0]        bus_addr,
  output logic [7:0]        bus_wdata,
  input  logic              bus_done,
  input  logic [7:0]        bus_rdata,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              halted,
  output logic [3:0]        error
);

  localparam logic [ADDR_W-1:0] PC_MAX = ADDR_W'(MEMORY_SIZE);

  state_e              state;
  logic [ADDR_W-1:0]   pc;
  logic [DELAY_W-1:0]  dly_cnt;

  logic [7:0]          opc;
  logic [7:0]          raddr;
  logic [15:0]         opnd;
  logic [ADDR_W-1:0]   jmp_tgt;
  logic                jmp_bad;
  logic [DELAY_W-1:0]  dly_ld;
  logic                pc_last;
  logic                do_adv;
  logic                rd_fin;

  assign opc     = reg_data[OPC_MSB:OPC_LSB];
  assign raddr   = reg_data[RADDR_MSB:RADDR_LSB];
  assign opnd    = reg_data[OPND_MSB:OPND_LSB];
  assign jmp_tgt = opnd[ADDR_W-1:0];
  // One extra bit keeps the comparison meaningful when the address space is a full power of two.
  assign jmp_bad = (ADDR_W+1)'(jmp_tgt) > (ADDR_W+1)'(MEMORY_SIZE);
  assign dly_ld  = DELAY_W'(opnd);
  assign pc_last = (pc == PC_MAX);

  assign busy   = !(state inside {S_IDLE, S_HALTED, S_ERROR});
  assign halted = (state == S_HALTED);

  // Flag every point where the current instruction retires and pc must step forward.
  always_comb begin
    do_adv = 1'b0;
    case (state)
      S_DECODE:  do_adv = (mem_error == 4'h0) &&
                          ((opc == OP_NOP) || ((opc == OP_DELAY) && (dly_ld == '0)));
      S_ISSUE:   do_adv = bus_ack && bus_done;
      S_WAITBUS: do_adv = bus_done;
      S_DELAY:   do_adv = (dly_cnt <= DELAY_W'(1));
      default:   do_adv = 1'b0;
    endcase
  end

  // A retiring bus transaction that was a read hands its data to the display path.
  assign rd_fin = do_adv && bus_rw && (state == S_ISSUE || state == S_WAITBUS);

  // Main sequencer FSM with bus fields, delay counter and sticky error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      pc        <= '0;
      reg_addr  <= '0;
      dly_cnt   <= '0;
      bus_req   <= 1'b0;
      bus_rw    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      error     <= ERR_NONE;
    end else begin
      rd_valid <= 1'b0;
      if (rd_fin) begin
        rd_data  <= bus_rdata;
        rd_valid <= 1'b1;
      end
      case (state)
        S_IDLE, S_HALTED, S_ERROR: begin
          if (start) begin
            pc    <= '0;
            error <= ERR_NONE;
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          reg_addr <= pc;
          state    <= S_MEMWAIT;
        end
        S_MEMWAIT: state <= S_DECODE;
        S_DECODE: begin
          if (mem_error != 4'h0) begin
            error <= mem_error;
            state <= S_ERROR;
          end else begin
            case (opc)
              OP_NOP: ;
              OP_WRITE, OP_READ: begin
                bus_rw    <= (opc == OP_READ);
                bus_addr  <= raddr;
                bus_wdata <= opnd[7:0];
                bus_req   <= 1'b1;
                state     <= S_ISSUE;
              end
              OP_JUMP: begin
                if (jmp_bad) begin
                  error <= ERR_JUMP;
                  state <= S_ERROR;
                end else begin
                  pc    <= jmp_tgt;
                  state <= S_FETCH;
                end
              end
              OP_DELAY: begin
                dly_cnt <= dly_ld;
                if (dly_ld != '0) state <= S_DELAY;
              end
              OP_HALT: state <= S_HALTED;
              default: begin
                error <= ERR_OPCODE;
                state <= S_ERROR;
              end
            endcase
          end
        end
        S_ISSUE: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            state   <= S_WAITBUS;
          end
        end
        S_WAITBUS: ;
        S_DELAY: dly_cnt <= dly_cnt - DELAY_W'(1);
        default: state <= S_IDLE;
      endcase
      // Retirement overrides the per-state next state; stepping past the top is an error.
      if (do_adv) begin
        if (pc_last) begin
          error <= ERR_PC_OVF;
          state <= S_ERROR;
        end else begin
          pc    <= pc + ADDR_W'(1);
          state <= S_FETCH;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: register memory model, bus master model with
// configurable or random latencies, and an instruction-level reference model.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  reg_addr;
  logic [31:0] reg_data = '0;
  logic [3:0]  mem_error = '0;
  logic        bus_req;
  logic        bus_ack = 1'b0;
  logic        bus_rw;
  logic [7:0]  bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_done = 1'b0;
  logic [7:0]  bus_rdata = '0;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        busy;
  logic        halted;
  logic [3:0]  error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_sequencer #(.MEMORY_SIZE(255), .DELAY_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .reg_addr(reg_addr), .reg_data(reg_data), .mem_error(mem_error),
    .bus_req(bus_req), .bus_ack(bus_ack), .bus_rw(bus_rw),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_done(bus_done), .bus_rdata(bus_rdata),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .halted(halted), .error(error)
  );

  // ---------------- register memory: data lags the address by over a cycle
  logic [31:0] mem  [256];
  logic [3:0]  merr [256];
  logic [7:0]  addr_d = '0;

  always @(negedge clk) begin
    reg_data  = mem[addr_d];
    mem_error = merr[addr_d];
    addr_d    = reg_addr;
  end

  // ---------------- bus master model
  int          ack_dly = 1, done_dly = 1;
  bit          rand_bus = 0, fix_rd = 0;
  logic [7:0]  fix_val = '0;
  logic [16:0] obs_tx[$];
  logic [7:0]  obs_rdat[$];
  logic [7:0]  obs_rd[$];
  int          stab_bad = 0, req_bad = 0, rdv_run_bad = 0, busy_cyc = 0;
  bit          fetched [256];
  int          bm_ph = 0, bm_cnt = 0, bm_done = 0;
  logic [16:0] bm_hold = '0;
  bit          rdv_prev = 0;

  always @(negedge clk) begin
    bus_ack  = 1'b0;
    bus_done = 1'b0;
    if (!reset_n) begin
      bm_ph = 0;
    end else begin
      if (bm_ph == 2) begin
        if (bus_req) req_bad++;
        bm_cnt--;
        if (bm_cnt <= 0) begin
          bus_done = 1'b1;
          bm_ph = 0;
        end
      end else if (bm_ph == 1) begin
        if (!bus_req || {bus_rw, bus_addr, bus_wdata} != bm_hold) stab_bad++;
      end else if (bus_req) begin
        bm_hold = {bus_rw, bus_addr, bus_wdata};
        obs_tx.push_back(bm_hold);
        bm_cnt  = rand_bus ? int'($urandom_range(0, 3)) : ack_dly;
        bm_done = rand_bus ? int'($urandom_range(0, 3)) : done_dly;
        bus_rdata = fix_rd ? fix_val : 8'($urandom);
        if (bus_rw) obs_rdat.push_back(bus_rdata);
        bm_ph = 1;
      end
      if (bm_ph == 1) begin
        if (bm_cnt == 0) begin
          bus_ack = 1'b1;
          if (bm_done == 0) begin
            bus_done = 1'b1;
            bm_ph = 0;
          end else begin
            bm_cnt = bm_done;
            bm_ph = 2;
          end
        end else begin
          bm_cnt--;
        end
      end
    end
  end

  // ---------------- monitor: busy cycles, fetched addresses, read results
  always @(negedge clk) begin
    if (busy) begin
      busy_cyc++;
      fetched[reg_addr] = 1'b1;
    end
    if (rd_valid) begin
      obs_rd.push_back(rd_data);
      if (rdv_prev) rdv_run_bad++;
    end
    rdv_prev = rd_valid;
  end

  // ---------------- reference model: interprets the program instruction by instruction
  logic [16:0] exp_tx[$];
  logic [3:0]  exp_err;
  bit          exp_halt;
  int          exp_cyc;

  function automatic void model(input int max_tx);
    int pc, nxt, steps;
    logic [31:0] w;
    pc = 0; steps = 0;
    exp_tx.delete(); exp_err = 4'h0; exp_halt = 1'b0; exp_cyc = 0;
    while (steps < 2000 && exp_tx.size() < max_tx) begin
      w = mem[pc];
      nxt = pc + 1;
      steps++;
      exp_cyc += 3;
      if (merr[pc] != 4'h0) begin exp_err = merr[pc]; return; end
      case (w[31:24])
        8'h00: ;
        8'h01: exp_tx.push_back({1'b0, w[23:16], w[7:0]});
        8'h02: exp_tx.push_back({1'b1, w[23:16], 8'h00});
        8'h03: nxt = int'(w[7:0]);
        8'h04: exp_cyc += int'(w[15:0]);
        8'h0F: begin exp_halt = 1'b1; return; end
        default: begin exp_err = 4'h2; return; end
      endcase
      if (w[31:24] != 8'h03 && pc == 255) begin exp_err = 4'h4; return; end
      pc = nxt;
    end
  endfunction

  function automatic logic [31:0] ins(input logic [7:0] op, input logic [7:0] ra,
                                      input logic [15:0] od);
    return {op, ra, od};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      mem[i]  = 32'h0F00_0000;
      merr[i] = 4'h0;
    end
  endtask

  task automatic clear_logs();
    obs_tx.delete(); obs_rdat.delete(); obs_rd.delete();
    stab_bad = 0; req_bad = 0; rdv_run_bad = 0;
    for (int i = 0; i < 256; i++) fetched[i] = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Pulse start and wait for the sequencer to go idle; optional second start mid-run.
  task automatic run_prog(input int extra_start_at, output bit to);
    int n;
    clear_logs();
    @(negedge clk);
    busy_cyc = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
      start = (n == extra_start_at);
    end
    start = 1'b0;
    to = busy;
    if (to) do_reset();
  endtask

  // ---------------- tests
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({reg_addr, bus_req, bus_rw, bus_addr, bus_wdata, rd_data, rd_valid,
         busy, halted, error} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got addr=%0h req=%0b rw=%0b baddr=%0h wd=%0h rd=%0h rv=%0b busy=%0b halt=%0b err=%0h expected all 0",
               reg_addr, bus_req, bus_rw, bus_addr, bus_wdata, rd_data, rd_valid, busy, halted, error);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write();
    bit to;
    clear_mem();
    mem[0] = ins(8'h01, 8'h2D, 16'h0008);
    mem[1] = ins(8'h0F, 8'h00, 16'h0000);
    rand_bus = 0; fix_rd = 0; ack_dly = 1; done_dly = 2;
    run_prog(-1, to);
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL write_timeout: got busy after bound expected idle"); end
    checks++;
    if (obs_tx.size() != 1) begin
      errors++; $display("FAIL write_count: got %0d expected 1", obs_tx.size());
    end else begin
      checks++;
      if (obs_tx[0] !== {1'b0, 8'h2D, 8'h08}) begin
        errors++; $display("FAIL write_fields: got %0h expected %0h", obs_tx[0], {1'b0, 8'h2D, 8'h08});
      end
    end
    checks++;
    if ({halted, busy, error} !== {1'b1, 1'b0, 4'h0}) begin
      errors++; $display("FAIL write_end: got halted=%0b busy=%0b err=%0h expected 1 0 0", halted, busy, error);
    end
  endtask

  task automatic test_read();
    bit to;
    clear_mem();
    mem[0] = ins(8'h02, 8'h32, 16'h0000);
    mem[1] = ins(8'h0F, 8'h00, 16'h0000);
    rand_bus = 0; fix_rd = 1; fix_val = 8'hA5; ack_dly = 0; done_dly = 2;
    run_prog(-1, to);
    fix_rd = 0;
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL read_timeout: got busy after bound expected idle"); end
    checks++;
    if (obs_tx.size() != 1 || obs_tx[0][16:8] !== {1'b1, 8'h32}) begin
      errors++; $display("FAIL read_txn: got n=%0d expected one read of reg 32", obs_tx.size());
    end
    checks++;
    if (obs_rd.size() != 1 || rd_data !== 8'hA5 || rdv_run_bad != 0) begin
      errors++; $display("FAIL read_data: got pulses=%0d rd=%0h runs=%0d expected 1 a5 0", obs_rd.size(), rd_data, rdv_run_bad);
    end
    checks++;
    if (halted !== 1'b1) begin errors++; $display("FAIL read_halt: got %0b expected 1", halted); end
  endtask

  task automatic test_delay();
    bit to;
    int n;
    clear_mem();
    mem[0] = ins(8'h04, 8'h00, 16'd5);
    mem[1] = ins(8'h00, 8'h00, 16'h0000);
    mem[2] = ins(8'h0F, 8'h00, 16'h0000);
    for (int r = 0; r < 2; r++) begin
      // second pass also pulses start in the middle of DELAY, which must be ignored
      run_prog(r == 0 ? -1 : 5, to);
      checks++;
      if (to !== 1'b0 || busy_cyc != 14 || halted !== 1'b1) begin
        errors++; $display("FAIL delay5_run%0d: got cycles=%0d halted=%0b expected 14 1", r, busy_cyc, halted);
      end
    end
    for (int r = 0; r < 4; r++) begin
      n = (r == 0) ? 0 : int'($urandom_range(1, 40));
      mem[0] = ins(8'h04, 8'h00, 16'(n));
      model(1000);
      run_prog(-1, to);
      checks++;
      if (to !== 1'b0 || busy_cyc != exp_cyc || halted !== 1'b1) begin
        errors++; $display("FAIL delay_rand n=%0d: got cycles=%0d halted=%0b expected %0d 1", n, busy_cyc, halted, exp_cyc);
      end
    end
  endtask

  task automatic test_jump();
    int n;
    clear_mem();
    mem[0] = ins(8'h03, 8'h00, 16'h0002);
    mem[1] = ins(8'h01, 8'h11, 16'h0022);
    mem[2] = ins(8'h02, 8'h33, 16'h0000);
    mem[3] = ins(8'h03, 8'h00, 16'h0002);
    rand_bus = 0; fix_rd = 0; ack_dly = 3; done_dly = 1;
    clear_logs();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (obs_tx.size() < 4 && n < 500) begin @(negedge clk); n++; end
    repeat (6) @(negedge clk);
    checks++;
    if (n >= 500) begin errors++; $display("FAIL jump_timeout: got %0d txns expected 4", obs_tx.size()); end
    checks++;
    if (fetched[1] !== 1'b0 || fetched[2] !== 1'b1) begin
      errors++; $display("FAIL jump_fetch: got addr1=%0b addr2=%0b expected 0 1", fetched[1], fetched[2]);
    end
    foreach (obs_tx[i]) begin
      checks++;
      if (obs_tx[i][16:8] !== {1'b1, 8'h33}) begin
        errors++; $display("FAIL jump_txn%0d: got %0h expected read of reg 33", i, obs_tx[i]);
      end
    end
    checks++;
    if (stab_bad != 0 || req_bad != 0) begin
      errors++; $display("FAIL jump_stable: got unstable=%0d req_after_ack=%0d expected 0 0", stab_bad, req_bad);
    end
    checks++;
    if (obs_rd.size() < 4) begin
      errors++; $display("FAIL jump_rd_count: got %0d expected at least 4", obs_rd.size());
    end
    foreach (obs_rd[i]) begin
      checks++;
      if (i >= obs_rdat.size() || obs_rd[i] !== obs_rdat[i]) begin
        errors++; $display("FAIL jump_rd%0d: got %0h expected the value returned by the bus", i, obs_rd[i]);
      end
    end
    do_reset();
  endtask

  task automatic test_errors();
    bit to;
    clear_mem();
    rand_bus = 0; ack_dly = 1; done_dly = 1;
    mem[0] = ins(8'h77, 8'h00, 16'h0000);
    run_prog(-1, to);
    checks++;
    if (to !== 1'b0 || error !== 4'h2 || busy !== 1'b0 || halted !== 1'b0 || obs_tx.size() != 0) begin
      errors++; $display("FAIL err_opcode: got err=%0h busy=%0b halt=%0b txns=%0d expected 2 0 0 0", error, busy, halted, obs_tx.size());
    end
    clear_mem();
    merr[0] = 4'h1;
    run_prog(-1, to);
    checks++;
    if (to !== 1'b0 || error !== 4'h1 || busy !== 1'b0) begin
      errors++; $display("FAIL err_mem: got err=%0h busy=%0b expected 1 0", error, busy);
    end
    clear_mem();
    mem[0]   = ins(8'h03, 8'h00, 16'h00FF);
    mem[255] = ins(8'h00, 8'h00, 16'h0000);
    model(1000);
    run_prog(-1, to);
    checks++;
    if (to !== 1'b0 || error !== exp_err || busy_cyc != exp_cyc) begin
      errors++; $display("FAIL err_pc_ovf: got err=%0h cycles=%0d expected %0h %0d", error, busy_cyc, exp_err, exp_cyc);
    end
    clear_mem();
    run_prog(-1, to);
    checks++;
    if (to !== 1'b0 || error !== 4'h0 || halted !== 1'b1) begin
      errors++; $display("FAIL err_cleared: got err=%0h halted=%0b expected 0 1", error, halted);
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    int n;
    clear_mem();
    mem[0] = ins(8'h01, 8'h40, 16'h0099);
    mem[1] = ins(8'h0F, 8'h00, 16'h0000);
    rand_bus = 0; ack_dly = 50; done_dly = 1;
    clear_logs();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (!bus_req && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (bus_req !== 1'b1) begin errors++; $display("FAIL mid_req: got %0b expected 1", bus_req); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({reg_addr, bus_req, bus_rw, bus_addr, bus_wdata, rd_data, rd_valid,
         busy, halted, error} !== '0) begin
      errors++; $display("FAIL mid_reset_outputs: got req=%0b busy=%0b baddr=%0h wd=%0h expected all 0", bus_req, busy, bus_addr, bus_wdata);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    ack_dly = 1;
    run_prog(-1, to);
    checks++;
    if (to !== 1'b0 || halted !== 1'b1 || obs_tx.size() != 1 || obs_tx[0] !== {1'b0, 8'h40, 8'h99}) begin
      errors++; $display("FAIL mid_rerun: got halted=%0b txns=%0d expected 1 1", halted, obs_tx.size());
    end
  endtask

  task automatic test_random();
    bit to;
    int len, r, tgt;
    logic [16:0] ob;
    for (int it = 0; it < 20; it++) begin
      clear_mem();
      len = int'($urandom_range(3, 10));
      for (int pc = 0; pc < len; pc++) begin
        r = int'($urandom_range(0, 99));
        tgt = int'($urandom_range(pc + 1, len));
        if (r < 25)      mem[pc] = ins(8'h01, 8'($urandom), 16'($urandom));
        else if (r < 45) mem[pc] = ins(8'h02, 8'($urandom), 16'($urandom));
        else if (r < 60) mem[pc] = ins(8'h00, 8'($urandom), 16'($urandom));
        else if (r < 75) mem[pc] = ins(8'h04, 8'h00, 16'($urandom_range(0, 6)));
        else if (r < 85) mem[pc] = ins(8'h03, 8'h00, 16'(tgt));
        else             mem[pc] = ins(8'h00, 8'h00, 16'h0000);
      end
      if (it % 5 == 3) mem[$urandom_range(0, len - 1)] = ins(8'h10 + 8'($urandom_range(0, 200)), 8'h00, 16'h0);
      if (it % 5 == 4) merr[$urandom_range(0, len)] = 4'($urandom_range(1, 15));
      rand_bus = 1;
      model(1000);
      run_prog(-1, to);
      rand_bus = 0;
      checks++;
      if (to !== 1'b0 || obs_tx.size() != exp_tx.size()) begin
        errors++; $display("FAIL rand%0d_count: got txns=%0d to=%0b expected %0d", it, obs_tx.size(), to, exp_tx.size());
      end else begin
        foreach (exp_tx[i]) begin
          ob = obs_tx[i];
          if (ob[16]) ob[7:0] = 8'h00;
          checks++;
          if (ob !== exp_tx[i]) begin
            errors++; $display("FAIL rand%0d_txn%0d: got %0h expected %0h", it, i, ob, exp_tx[i]);
          end
        end
      end
      checks++;
      if (obs_rd.size() != obs_rdat.size() || rdv_run_bad != 0) begin
        errors++; $display("FAIL rand%0d_rdcount: got %0d expected %0d", it, obs_rd.size(), obs_rdat.size());
      end else begin
        foreach (obs_rd[i]) begin
          checks++;
          if (obs_rd[i] !== obs_rdat[i]) begin
            errors++; $display("FAIL rand%0d_rd%0d: got %0h expected %0h", it, i, obs_rd[i], obs_rdat[i]);
          end
        end
      end
      checks++;
      if (error !== exp_err || halted !== exp_halt || stab_bad != 0 || req_bad != 0) begin
        errors++; $display("FAIL rand%0d_end: got err=%0h halt=%0b unstable=%0d req=%0d expected %0h %0b 0 0",
                           it, error, halted, stab_bad, req_bad, exp_err, exp_halt);
      end
      if (exp_tx.size() == 0) begin
        checks++;
        if (busy_cyc != exp_cyc) begin
          errors++; $display("FAIL rand%0d_cycles: got %0d expected %0d", it, busy_cyc, exp_cyc);
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_mem();
    clear_logs();
    test_reset();
    test_write();
    test_read();
    test_delay();
    test_jump();
    test_errors();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Walks the instruction words held in the register memory and decodes each one.
- Issues sensor register write/read transactions to the serial bus master (SPI/I2C engine) over a req/done handshake, and returns read data to the display path.
- Sits between the register memory and the bus master; it is the only driver of the memory address.

Parameters:
MEMORY_SIZE, 255, highest valid instruction address; address width ADDR_W = $clog2(MEMORY_SIZE+1) (8 at default)
DELAY_W, 16, width of the DELAY opcode cycle counter

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins execution at address 0 (ignored unless IDLE/HALTED/ERROR)
reg_addr  out  ADDR_W  instruction address to register memory
reg_data  in  32  instruction word; valid 2 cycles after reg_addr changes
mem_error  in  4  register memory error code; nonzero = bad fetch
bus_req  out  1  transaction request, held until bus_ack
bus_ack  in  1  bus master accepted request
bus_rw  out  1  1 = read, 0 = write; stable while bus_req high
bus_addr  out  8  sensor register address
bus_wdata  out  8  write data
bus_done  in  1  one-cycle pulse: transaction complete
bus_rdata  in  8  read data, valid with bus_done
rd_data  out  8  last read result
rd_valid  out  1  one-cycle pulse when rd_data updates
busy  out  1  high in any state other than IDLE/HALTED/ERROR
halted  out  1  high in HALTED
error  out  4  sticky error code; 0 = none

Behaviour:
- Instruction format: [31:24] opcode, [23:16] sensor reg address, [15:0] operand.
- Opcodes: 0x00 NOP; 0x01 WRITE (bus_wdata = operand[7:0]); 0x02 READ; 0x03 JUMP (target = operand[ADDR_W-1:0]); 0x04 DELAY (operand = cycle count); 0x0F HALT.
- Reset (async, reset_n low): state IDLE, pc=0, reg_addr=0, bus_req=0, bus_rw=0, bus_addr=0, bus_wdata=0, rd_data=0, rd_valid=0, error=0. busy and halted are 0.
- States: IDLE, FETCH, MEMWAIT, DECODE, ISSUE, WAITBUS, DELAY, HALTED, ERROR.
- IDLE/HALTED/ERROR + start: pc=0, error cleared, go to FETCH.
- FETCH: reg_addr<=pc, go to MEMWAIT. MEMWAIT: one cycle, go to DECODE. DECODE samples reg_data/mem_error, so the fetch-to-decode latency is 3 cycles.
- DECODE:
  - mem_error!=0: error<=mem_error, go to ERROR.
  - NOP: pc++, go to FETCH.
  - WRITE/READ: load bus_rw/bus_addr/bus_wdata, assert bus_req, go to ISSUE.
  - JUMP: target>MEMORY_SIZE gives error=4'h3 and ERROR; otherwise pc=target, go to FETCH.
  - DELAY: counter=operand; operand 0 behaves as NOP; otherwise go to DELAY.
  - HALT: go to HALTED.
  - Any other opcode: error=4'h2, go to ERROR.
- ISSUE: hold bus_req and the bus fields until bus_ack. On the cycle bus_ack is sampled high, bus_req<=0 and go to WAITBUS.
- WAITBUS: on bus_done, for READ: rd_data<=bus_rdata and rd_valid=1 for one cycle. Then pc++ and go to FETCH. bus_done and bus_ack in the same cycle inside ISSUE: treat as ack then done (complete directly).
- DELAY: decrement each cycle; when counter reaches 1, pc++ and go to FETCH, for exactly operand cycles in DELAY.
- pc wrap: pc++ at MEMORY_SIZE gives error=4'h4 and ERROR (no silent wrap).
- start while busy: ignored.
- reset_n asserted mid-transaction: all outputs return to reset values immediately. bus_req drops asynchronously; the bus master must tolerate an abandoned request.
- error is sticky until the next accepted start or reset.

Decomposition:
- Shared package seq_pkg:
  - opcode enum (OP_NOP, OP_WRITE, OP_READ, OP_JUMP, OP_DELAY, OP_HALT)
  - state enum
  - error code constants: ERR_NONE=0, ERR_MEM=1 (memory codes passed through), ERR_OPCODE=2, ERR_JUMP=3, ERR_PC_OVF=4
  - instruction field bit positions
- No sub-module; the delay counter lives inline. The bench pairs the block with register_memory and a bus master model.

Test Plan:
- Program {WRITE 0x2D←0x08, HALT}, start -> one bus_req with bus_rw=0, bus_addr=0x2D, bus_wdata=0x08; halted=1 after bus_done; error=0.
- Program {READ 0x32, HALT}, model returns 0xA5 -> rd_data=0xA5, single-cycle rd_valid, then halted=1.
- {DELAY 5, NOP, HALT} -> exactly 5 cycles in DELAY; HALT decoded at the expected cycle; start again re-runs from pc 0.
- {JUMP 0x02, WRITE.., READ 0x33, JUMP 0x02} -> address 1 never fetched; READ repeats; bus_ack delayed 3 cycles keeps bus_req/bus_addr stable.
- Opcode 0x77 at addr 0 -> error=2, busy=0, no bus_req; mem_error=1 on fetch -> error=1.
- reset_n low while waiting in ISSUE -> bus_req=0 same cycle, state IDLE, all outputs at reset values; start afterwards runs normally.
